// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: pixel mode encodings,
// capture FSM state type and the sensor's native resolution.
package cam_pkg;

  localparam logic [1:0] MODE_Y      = 2'd0;
  localparam logic [1:0] MODE_RGB565 = 2'd1;
  localparam logic [1:0] MODE_RAW    = 2'd2;

  localparam int OV7670_H_RES = 640;
  localparam int OV7670_V_RES = 480;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } cap_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for an asynchronous camera signal, with a third
// stage used only to derive single-cycle rising/falling edge pulses.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture controller: assembles camera bytes into pixels, decimates,
// and drives the framebuffer write port. Optional CAM_TEST_PATTERN_EN adds
// a {col,line} test pattern selected by test_pat.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_RES  = OV7670_H_RES,
  parameter int V_RES  = OV7670_V_RES,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_24,
  input  logic              rst,
  input  logic              capture_en,
  input  logic [1:0]        mode,
  input  logic              test_pat,
  input  logic              PCLK,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int DSH      = $clog2(DECIM);
  localparam int CW       = ($clog2(H_RES + 1) > 8) ? $clog2(H_RES + 1) : 8;
  localparam int LW       = ($clog2(V_RES + 1) > 8) ? $clog2(V_RES + 1) : 8;
  localparam int ROW_STEP = H_RES / DECIM;

  logic pclk_rise, href_lvl, href_fall, vsync_rise, vsync_fall;
  logic unused_pclk_lvl, unused_pclk_fall, unused_href_rise, unused_vsync_lvl;

  cam_sync_edge u_sync_pclk (
    .clk(CLOCK_24), .rst(rst), .din(PCLK),
    .level(unused_pclk_lvl), .rise(pclk_rise), .fall(unused_pclk_fall)
  );
  cam_sync_edge u_sync_href (
    .clk(CLOCK_24), .rst(rst), .din(HREF),
    .level(href_lvl), .rise(unused_href_rise), .fall(href_fall)
  );
  cam_sync_edge u_sync_vsync (
    .clk(CLOCK_24), .rst(rst), .din(VSYNC),
    .level(unused_vsync_lvl), .rise(vsync_rise), .fall(vsync_fall)
  );

  cap_state_t        state;
  logic [7:0]        d_s1, d_s2;
  logic [7:0]        hi_byte;
  logic              byte_idx;
  logic [1:0]        mode_q;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line_cnt;
  logic [ADDR_W-1:0] row_base;

`ifdef CAM_TEST_PATTERN_EN
  logic tp_q;
`else
  logic unused_test_pat;
  assign unused_test_pat = test_pat;
`endif

  logic              pix_done;
  logic [15:0]       pix_data;
  logic              col_ok, line_ok, col_kept, line_kept;
  logic [ADDR_W-1:0] addr_nxt;

  always_comb begin
    pix_done = 1'b0;
    pix_data = '0;
    case (mode_q)
      MODE_Y: begin
        pix_done = ~byte_idx;
        pix_data = {8'h00, d_s2};
      end
      MODE_RGB565: begin
        pix_done = byte_idx;
        pix_data = {hi_byte, d_s2};
      end
      default: begin
        pix_done = 1'b1;
        pix_data = {8'h00, d_s2};
      end
    endcase
  end

  // Counters saturate at the limit so overflow stays detectable without wrap.
  assign col_ok    = col < CW'(H_RES);
  assign line_ok   = line_cnt < LW'(V_RES);
  assign col_kept  = (col & CW'(DECIM - 1)) == '0;
  assign line_kept = line_ok && ((line_cnt & LW'(DECIM - 1)) == '0);
  assign addr_nxt  = row_base + ADDR_W'(col >> DSH);
  assign state_dbg = state;

  always_ff @(posedge CLOCK_24) begin
    if (rst) begin
      state      <= ST_IDLE;
      d_s1       <= '0;
      d_s2       <= '0;
      hi_byte    <= '0;
      byte_idx   <= 1'b0;
      mode_q     <= MODE_Y;
      col        <= '0;
      line_cnt   <= '0;
      row_base   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
`ifdef CAM_TEST_PATTERN_EN
      tp_q       <= 1'b0;
`endif
    end else begin
      d_s1       <= D;
      d_s2       <= d_s1;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (capture_en) begin
            state <= ST_WAIT_FRAME;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        ST_WAIT_FRAME: begin
          if (vsync_fall) begin
            state    <= ST_ACTIVE;
            col      <= '0;
            line_cnt <= '0;
            byte_idx <= 1'b0;
            row_base <= '0;
            mode_q   <= mode;
`ifdef CAM_TEST_PATTERN_EN
            tp_q     <= test_pat;
`endif
          end
        end
        ST_ACTIVE: begin
          if (vsync_rise) begin
            frame_done <= 1'b1;
            if (capture_en) begin
              state <= ST_WAIT_FRAME;
              err   <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (pclk_rise && href_lvl) begin
            if (!byte_idx) hi_byte <= d_s2;
            if (mode_q == MODE_Y || mode_q == MODE_RGB565) byte_idx <= ~byte_idx;
            if (pix_done) begin
              if (!col_ok || !line_ok) begin
                err <= 1'b1;
              end else if (col_kept && line_kept) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_nxt;
`ifdef CAM_TEST_PATTERN_EN
                wr_data <= tp_q ? DATA_W'({col[7:0], line_cnt[7:0]}) : DATA_W'(pix_data);
`else
                wr_data <= DATA_W'(pix_data);
`endif
              end
              if (col_ok) col <= col + CW'(1);
            end
          end else if (href_fall) begin
            col      <= '0;
            byte_idx <= 1'b0;
            if (line_kept) row_base <= row_base + ADDR_W'(ROW_STEP);
            if (line_ok) line_cnt <= line_cnt + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: two instances (4x2 full-rate, 8x4 decimate-by-2)
// share the camera pins; each has its own capture_en.
module tb_cam_capture_ctrl;
  import cam_pkg::*;

  logic       CLOCK_24 = 1'b0;
  logic       rst = 1'b1;
  logic       cap_a = 1'b0, cap_b = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       test_pat = 1'b0;
  logic       PCLK = 1'b0, VSYNC = 1'b1, HREF = 1'b0;
  logic [7:0] D = 8'h00;

  logic        wr_en_a, frame_done_a, busy_a, err_a;
  logic [7:0]  wr_addr_a;
  logic [15:0] wr_data_a;
  logic [1:0]  state_a;
  logic        wr_en_b, frame_done_b, busy_b, err_b;
  logic [7:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [1:0]  state_b;

  cam_capture_ctrl #(.H_RES(4), .V_RES(2), .DECIM(1), .ADDR_W(8), .DATA_W(16)) dut_a (
    .CLOCK_24(CLOCK_24), .rst(rst), .capture_en(cap_a), .mode(mode), .test_pat(test_pat),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .frame_done(frame_done_a),
    .busy(busy_a), .err(err_a), .state_dbg(state_a)
  );

  cam_capture_ctrl #(.H_RES(8), .V_RES(4), .DECIM(2), .ADDR_W(8), .DATA_W(16)) dut_b (
    .CLOCK_24(CLOCK_24), .rst(rst), .capture_en(cap_b), .mode(mode), .test_pat(test_pat),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .frame_done(frame_done_b),
    .busy(busy_b), .err(err_b), .state_dbg(state_b)
  );

  // Clock and reset
  always #5 CLOCK_24 = ~CLOCK_24;

  int checks = 0;
  int passed = 0;
  int fd_a = 0, fd_b = 0;
  logic [23:0] obs_a[$], obs_b[$], exp_q[$];
  logic [7:0]  byte_q[$];

  // Write monitor: {addr, data} per strobe, sampled away from the active edge.
  always @(negedge CLOCK_24) begin
    if (wr_en_a) obs_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) obs_b.push_back({wr_addr_b, wr_data_b});
    if (frame_done_a) fd_a++;
    if (frame_done_b) fd_b++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_24);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    PCLK = 1'b0;
    D    = b;
    tick(3);
    PCLK = 1'b1;
    tick(3);
  endtask

  task automatic send_line();
    HREF = 1'b1;
    tick(2);
    foreach (byte_q[i]) send_byte(byte_q[i]);
    PCLK = 1'b0;
    tick(3);
    HREF = 1'b0;
    tick(4);
  endtask

  task automatic frame_begin();
    VSYNC = 1'b1;
    tick(4);
    VSYNC = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    VSYNC = 1'b1;
    tick(6);
  endtask

  // Tests
  task automatic test_reset();
    tick(3);
    checks++; if (wr_en_a !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en_a); else passed++;
    checks++; if (wr_addr_a !== 8'h00) $display("FAIL reset_wr_addr: got %h want 00", wr_addr_a); else passed++;
    checks++; if (wr_data_a !== 16'h0000) $display("FAIL reset_wr_data: got %h want 0000", wr_data_a); else passed++;
    checks++; if (frame_done_a !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
    checks++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else passed++;
    checks++; if (state_a !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_a); else passed++;
    rst = 1'b0;
    tick(3);
    checks++; if (busy_a !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_mode_y();
    int fd0;
    mode = 2'd0;
    cap_a = 1'b1;
    tick(2);
    checks++; if (busy_a !== 1'b1) $display("FAIL armed_busy: got %b want 1", busy_a); else passed++;
    checks++; if (state_a !== 2'd1) $display("FAIL armed_state: got %0d want 1", state_a); else passed++;
    obs_a.delete();
    fd0 = fd_a;
    frame_begin();
    checks++; if (state_a !== 2'd2) $display("FAIL active_state: got %0d want 2", state_a); else passed++;
    byte_q = '{8'h10, 8'h80, 8'h11, 8'h81, 8'h12, 8'h82, 8'h13, 8'h83};
    send_line();
    byte_q = '{8'h20, 8'h90, 8'h21, 8'h91, 8'h22, 8'h92, 8'h23, 8'h93};
    send_line();
    frame_end();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 16'h0010 + 16'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i + 4), 16'h0020 + 16'(i)});
    checks++; if (obs_a.size() !== exp_q.size()) $display("FAIL mode_y_count: got %0d want %0d", obs_a.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_a.size()) $display("FAIL mode_y_write%0d: got none want %h", i, exp_q[i]);
      else if (obs_a[i] !== exp_q[i]) $display("FAIL mode_y_write%0d: got %h want %h", i, obs_a[i], exp_q[i]);
      else passed++;
    end
    checks++; if (fd_a - fd0 !== 1) $display("FAIL mode_y_frame_done: got %0d want 1", fd_a - fd0); else passed++;
    checks++; if (state_a !== 2'd1) $display("FAIL mode_y_rearm: got %0d want 1", state_a); else passed++;
    checks++; if (err_a !== 1'b0) $display("FAIL mode_y_err: got %b want 0", err_a); else passed++;
  endtask

  task automatic test_rgb565();
    mode = 2'd1;
    obs_a.delete();
    frame_begin();
    mode = 2'd0;  // must be ignored mid-frame
    byte_q = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line();
    frame_end();
    exp_q = '{{8'd0, 16'hF800}, {8'd1, 16'h07E0}};
    checks++; if (obs_a.size() !== 2) $display("FAIL rgb_count: got %0d want 2", obs_a.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_a.size()) $display("FAIL rgb_write%0d: got none want %h", i, exp_q[i]);
      else if (obs_a[i] !== exp_q[i]) $display("FAIL rgb_write%0d: got %h want %h", i, obs_a[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_decim();
    int fd0;
    mode = 2'd2;
    cap_a = 1'b0;
    cap_b = 1'b1;
    tick(2);
    obs_b.delete();
    fd0 = fd_b;
    frame_begin();
    cap_b = 1'b0;
    for (int l = 0; l < 4; l++) begin
      byte_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
      send_line();
    end
    frame_end();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), 16'(2 * (i % 4))});
    checks++; if (obs_b.size() !== 8) $display("FAIL decim_count: got %0d want 8", obs_b.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_b.size()) $display("FAIL decim_write%0d: got none want %h", i, exp_q[i]);
      else if (obs_b[i] !== exp_q[i]) $display("FAIL decim_write%0d: got %h want %h", i, obs_b[i], exp_q[i]);
      else passed++;
    end
    checks++; if (err_b !== 1'b0) $display("FAIL decim_err: got %b want 0", err_b); else passed++;
    checks++; if (fd_b - fd0 !== 1) $display("FAIL decim_frame_done: got %0d want 1", fd_b - fd0); else passed++;
    checks++; if (busy_b !== 1'b0) $display("FAIL decim_idle_busy: got %b want 0", busy_b); else passed++;
  endtask

  task automatic test_overflow();
    mode = 2'd2;
    cap_a = 1'b1;
    tick(2);
    checks++; if (err_a !== 1'b0) $display("FAIL ovf_err_cleared_on_arm: got %b want 0", err_a); else passed++;
    obs_a.delete();
    frame_begin();
    byte_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_line();
    checks++; if (err_a !== 1'b1) $display("FAIL ovf_err_set: got %b want 1", err_a); else passed++;
    frame_end();
    checks++; if (obs_a.size() !== 4) $display("FAIL ovf_count: got %0d want 4", obs_a.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_a.size()) $display("FAIL ovf_write%0d: got none want %h", i, {8'(i), 16'h0030 + 16'(i)});
      else if (obs_a[i] !== {8'(i), 16'h0030 + 16'(i)}) $display("FAIL ovf_write%0d: got %h want %h", i, obs_a[i], {8'(i), 16'h0030 + 16'(i)});
      else passed++;
    end
    checks++; if (err_a !== 1'b0) $display("FAIL ovf_err_cleared_on_rearm: got %b want 0", err_a); else passed++;
  endtask

  task automatic test_capture_drop();
    int fd0;
    obs_a.delete();
    fd0 = fd_a;
    frame_begin();
    byte_q = '{8'h40, 8'h41, 8'h42, 8'h43};
    send_line();
    cap_a = 1'b0;
    byte_q = '{8'h50, 8'h51, 8'h52, 8'h53};
    send_line();
    frame_end();
    checks++; if (obs_a.size() !== 8) $display("FAIL drop_count: got %0d want 8", obs_a.size()); else passed++;
    checks++;
    if (obs_a.size() < 8) $display("FAIL drop_last_write: got none want %h", {8'd7, 16'h0053});
    else if (obs_a[7] !== {8'd7, 16'h0053}) $display("FAIL drop_last_write: got %h want %h", obs_a[7], {8'd7, 16'h0053});
    else passed++;
    checks++; if (fd_a - fd0 !== 1) $display("FAIL drop_frame_done: got %0d want 1", fd_a - fd0); else passed++;
    checks++; if (state_a !== 2'd0) $display("FAIL drop_state: got %0d want 0", state_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_reset_mid_line();
    int fd0;
    mode = 2'd2;
    cap_a = 1'b1;
    tick(2);
    obs_a.delete();
    frame_begin();
    HREF = 1'b1;
    tick(2);
    send_byte(8'h60);
    send_byte(8'h61);
    rst = 1'b1;
    tick(1);
    checks++; if (obs_a.size() !== 2) $display("FAIL rst_pre_writes: got %0d want 2", obs_a.size()); else passed++;
    checks++; if (wr_en_a !== 1'b0) $display("FAIL rst_mid_wr_en: got %b want 0", wr_en_a); else passed++;
    checks++; if (wr_addr_a !== 8'h00) $display("FAIL rst_mid_wr_addr: got %h want 00", wr_addr_a); else passed++;
    checks++; if (wr_data_a !== 16'h0000) $display("FAIL rst_mid_wr_data: got %h want 0000", wr_data_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy_a); else passed++;
    checks++; if (state_a !== 2'd0) $display("FAIL rst_mid_state: got %0d want 0", state_a); else passed++;
    rst = 1'b0;
    obs_a.delete();
    fd0 = fd_a;
    send_byte(8'h62);
    send_byte(8'h63);
    PCLK = 1'b0;
    tick(3);
    HREF = 1'b0;
    tick(4);
    frame_end();
    checks++; if (obs_a.size() !== 0) $display("FAIL rst_post_writes: got %0d want 0", obs_a.size()); else passed++;
    checks++; if (fd_a - fd0 !== 0) $display("FAIL rst_post_frame_done: got %0d want 0", fd_a - fd0); else passed++;
    checks++; if (state_a !== 2'd1) $display("FAIL rst_post_state: got %0d want 1", state_a); else passed++;
  endtask

`ifdef CAM_TEST_PATTERN_EN
  task automatic test_pattern();
    mode = 2'd2;
    test_pat = 1'b1;
    cap_a = 1'b1;
    tick(2);
    obs_a.delete();
    frame_begin();
    test_pat = 1'b0;
    for (int l = 0; l < 2; l++) begin
      byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_line();
    end
    frame_end();
    checks++; if (obs_a.size() !== 8) $display("FAIL tp_count: got %0d want 8", obs_a.size()); else passed++;
    checks++;
    if (obs_a.size() < 8) $display("FAIL tp_line1_col2: got none want %h", {8'd6, 16'h0201});
    else if (obs_a[6] !== {8'd6, 16'h0201}) $display("FAIL tp_line1_col2: got %h want %h", obs_a[6], {8'd6, 16'h0201});
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_mode_y();
    test_rgb565();
    test_decim();
    test_overflow();
    test_capture_drop();
    test_reset_mid_line();
`ifdef CAM_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
